// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CSUM_EN (adds the trailing checksum byte).
package imem_loader_pkg;

  // Loader FSM states; CSUM is only reachable when IMEM_LOADER_CSUM_EN is defined.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    DATA    = 3'd3,
    CSUM    = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_e;

  // Stream header: 16-bit little-endian word count.
  localparam int unsigned HDR_BYTES  = 2;
  // Program words are 32 bits, sent least-significant byte first.
  localparam int unsigned WORD_BYTES = 4;

  // States in which the loader takes bytes from the stream.
  function automatic logic is_rx_state(input state_e s);
    logic r;
    case (s)
      LEN_LO, LEN_HI, DATA: r = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:                 r = 1'b1;
`endif
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

  // States that count as "load in progress".
  function automatic logic is_busy_state(input state_e s);
    logic r;
    case (s)
      LEN_LO, LEN_HI, DATA, CSUM, RELEASE: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: gathers stream bytes LSB first into 32-bit words.
// word_o/word_valid_o are valid in the same cycle as the strobe that
// carries the final byte, so the parent can register the write directly.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        strobe_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  // Next lane / shift contents: clear wins, otherwise drop the byte into its lane.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = 2'd0;
      shift_d = 24'd0;
    end else if (strobe_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    shift_d[7:0]   = byte_i;
        2'd1:    shift_d[15:8]  = byte_i;
        2'd2:    shift_d[23:16] = byte_i;
        default: shift_d        = shift_q;  // top byte goes straight to word_o
      endcase
    end else begin
      lane_d  = lane_q;
      shift_d = shift_q;
    end
  end

  // Lane counter and partial-word register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word_o       = {byte_i, shift_q};
  assign word_valid_o = strobe_i && !clear_i && (lane_q == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer that streams a program image into imem and
// holds the core in reset until the image is complete.
// Optional feature macro: IMEM_LOADER_CSUM_EN (XOR checksum byte after the data).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned RST_RELEASE_DLY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH   = 17'(2 ** ADDR_W);
  localparam logic [3:0]  REL_DLY = 4'(RST_RELEASE_DLY);
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e POST_DATA = CSUM;
`else
  localparam state_e POST_DATA = RELEASE;
`endif

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [16:0]         widx_q, widx_d;
  logic [3:0]          dly_q, dly_d;
  logic                rx_ready_q, rx_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                accept_s;
  logic [15:0]         hdr_count_s;
  logic                last_word_s;
  logic                pk_clear_s;
  logic                pk_strobe_s;
  logic [31:0]         pk_word_s;
  logic                pk_word_valid_s;

  byte_packer u_packer (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (pk_clear_s),
    .strobe_i     (pk_strobe_s),
    .byte_i       (rx_data),
    .word_o       (pk_word_s),
    .word_valid_o (pk_word_valid_s)
  );

  assign accept_s    = rx_valid && rx_ready_q;
  assign hdr_count_s = {rx_data, count_q[7:0]};
  assign last_word_s = (widx_q == ({1'b0, count_q} - 17'd1));

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    widx_d      = widx_q;
    dly_d       = 4'd0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pk_clear_s  = 1'b0;
    pk_strobe_s = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          widx_d     = 17'd0;
          pk_clear_s = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      LEN_LO: begin
        if (accept_s) begin
          count_d = {count_q[15:8], rx_data};
          state_d = LEN_HI;
        end else begin
          state_d = LEN_LO;
        end
      end
      LEN_HI: begin
        if (accept_s) begin
          count_d = hdr_count_s;
          if (hdr_count_s == 16'd0) begin
            state_d = POST_DATA;
          end else if ({1'b0, hdr_count_s} > DEPTH) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = LEN_HI;
        end
      end
      DATA: begin
        if (accept_s) begin
          pk_strobe_s = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d      = csum_q ^ rx_data;
`endif
          if (pk_word_valid_s) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = widx_q[ADDR_W-1:0];
            mem_wdata_d = pk_word_s;
            widx_d      = widx_q + 17'd1;
            if (last_word_s) begin
              state_d = POST_DATA;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
        if (accept_s) begin
          if (rx_data == csum_q) begin
            state_d = RELEASE;
          end else begin
            state_d = ERR;
          end
        end else begin
          state_d = CSUM;
        end
`else
        state_d = IDLE;
`endif
      end
      RELEASE: begin
        if (dly_q == REL_DLY) begin
          state_d = DONE;
        end else begin
          dly_d   = dly_q + 4'd1;
          state_d = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d   = is_rx_state(state_d);
    busy_d       = is_busy_state(state_d);
    done_d       = (state_d == DONE);
    err_d        = (state_d == ERR);
    core_reset_d = (state_d != DONE);
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= 16'd0;
      widx_q       <= 17'd0;
      dly_q        <= 4'd0;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      dly_q        <= dly_d;
      rx_ready_q   <= rx_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign rx_ready   = rx_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench with a transaction-level model of the loader.
// The driver derives the expected writes and release time from the byte stream;
// one compare process checks them against the DUT on every cycle.
module tb_imem_loader;

  localparam int AW  = 4;
  localparam int DLY = 2;
  localparam int MODE_OK = 0, MODE_HDR_ERR = 1, MODE_BAD_CSUM = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, mem_we, core_reset, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  imem_loader #(.ADDR_W(AW), .RST_RELEASE_DLY(DLY)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset(core_reset),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] data; } exp_t;
  exp_t        exq[$];
  logic [31:0] img    [16];
  logic [31:0] tb_mem [16];
  int cyc = 0, last_acc = 0, exp_fall = -1, wr_cnt = 0;
  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model: write schedule, release timing, flag relations.
  always @(negedge clk) begin
    if (chk_en) begin
      while (exq.size() > 0 && exq[0].cyc < cyc) begin
        check("missed_write", 32'(exq[0].cyc), 32'(cyc));
        void'(exq.pop_front());
      end
      if (exq.size() > 0 && exq[0].cyc == cyc) begin
        check("mem_we", 32'(mem_we), 32'd1);
        check("mem_addr", 32'(mem_addr), 32'(exq[0].addr));
        check("mem_wdata", mem_wdata, exq[0].data);
        void'(exq.pop_front());
      end else begin
        check("no_spurious_we", 32'(mem_we), 32'd0);
      end
      if (mem_we) begin
        tb_mem[mem_addr] = mem_wdata;
        wr_cnt++;
      end
      if (exp_fall >= 0) begin
        if (cyc < exp_fall) begin
          check("core_reset_hold", 32'(core_reset), 32'd1);
        end else begin
          check("core_reset_fall", 32'(core_reset), 32'd0);
          check("done_set", 32'(done), 32'd1);
        end
      end
      check("busy_excl", 32'(busy && (done || err)), 32'd0);
      if (err) check("err_flags", {30'd0, core_reset, rx_ready}, 32'h2);
      if (done) check("done_core_reset", 32'(core_reset), 32'd0);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) tb_mem[i] = 32'hA5A5A5A5;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte after `gap` idle cycles and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("rx_ready_wait", 32'(rx_ready), 32'd1);
    last_acc = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Stream header + n_words of img[]; predicts each write and the core-reset release.
  task automatic do_load(input int n_words, input logic [15:0] hdr, input bit gaps,
                         input int start_mid, input int mode);
    logic [7:0]  x;
    logic [31:0] w;
    exp_t        e;
    x = 8'h00;
    exp_fall = -1;
    pulse_start();
    send_byte(hdr[7:0], 0);
    send_byte(hdr[15:8], 0);
    for (int i = 0; i < n_words; i++) begin
      w = img[i];
      for (int j = 0; j < 4; j++) begin
        x = x ^ w[8*j +: 8];
        if (start_mid == i*4 + j) pulse_start();
        send_byte(w[8*j +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
        if (j == 3) begin
          e.cyc = last_acc; e.addr = AW'(i); e.data = w;
          exq.push_back(e);
        end
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (mode != MODE_HDR_ERR) send_byte((mode == MODE_BAD_CSUM) ? (x ^ 8'h01) : x, 0);
`endif
    if (mode == MODE_OK) exp_fall = last_acc + DLY + 1;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || err) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("end_reached", 32'(done || err), 32'd1);
    check("writes_drained", 32'(exq.size()), 32'd0);
  endtask

  task automatic check_image(input string tag, input int n);
    for (int i = 0; i < n; i++) check($sformatf("%s_mem%0d", tag, i), tb_mem[i], img[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, {24'd0, rx_ready, mem_we, core_reset, busy, done, err, 2'd0}, 32'h20);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int          wc;
    exp_t        e;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Three-word image from the stream 03 00 EF BE AD DE 78 56 34 12 00 00 00 00.
    img[0] = 32'hDEADBEEF; img[1] = 32'h12345678; img[2] = 32'h00000000;
    do_load(3, 16'h0003, 1'b0, -1, MODE_OK);
    wait_end();
    check("w3_done", {29'd0, done, core_reset, busy}, 32'h4);
    check("w3_mem0", tb_mem[0], 32'hDEADBEEF);
    check("w3_mem1", tb_mem[1], 32'h12345678);
    check("w3_mem2", tb_mem[2], 32'h00000000);

    // Empty image: no writes, still completes.
    wc = wr_cnt;
    do_load(0, 16'h0000, 1'b0, -1, MODE_OK);
    wait_end();
    check("empty_writes", 32'(wr_cnt - wc), 32'd0);
    check("empty_done", {30'd0, done, core_reset}, 32'h2);

    // Count 17 exceeds a 16-word imem -> abort with the core held.
    do_load(0, 16'h0011, 1'b0, -1, MODE_HDR_ERR);
    wait_end();
    check("ovf_flags", {27'd0, err, done, rx_ready, core_reset, busy}, 32'h12);
    clear_mem();
    img[0] = 32'hCAFEF00D;
    do_load(1, 16'h0001, 1'b0, -1, MODE_OK);
    wait_end();
    check("recover_flags", {30'd0, done, err}, 32'h2);
    check("recover_mem0", tb_mem[0], 32'hCAFEF00D);

    // Stalled stream plus an ignored start in the middle of DATA.
    clear_mem();
    img[0] = 32'h0BADC0DE; img[1] = 32'h89ABCDEF;
    do_load(2, 16'h0002, 1'b1, 5, MODE_OK);
    wait_end();
    check("gap_done", 32'(done), 32'd1);
    check_image("gap", 2);

    // Reset after five data bytes, then a fresh load.
    img[0] = 32'h11223344; img[1] = 32'h55667788;
    exp_fall = -1;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int j = 0; j < 5; j++) begin
      w = (j < 4) ? img[0] : img[1];
      send_byte(w[8*(j%4) +: 8], 0);
      if (j == 3) begin
        e.cyc = last_acc; e.addr = '0; e.data = img[0];
        exq.push_back(e);
      end
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    chk_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;
    exq.delete();
    chk_en = 1'b1;
    @(negedge clk);
    clear_mem();
    img[0] = 32'h76543210; img[1] = 32'hFEDCBA98;
    do_load(2, 16'h0002, 1'b0, -1, MODE_OK);
    wait_end();
    check_image("post_reset", 2);

    // Full-depth image: last write lands on the top address.
    clear_mem();
    for (int i = 0; i < 16; i++) img[i] = 32'h10000000 + 32'(i) * 32'h01010101;
    do_load(16, 16'h0010, 1'b0, -1, MODE_OK);
    wait_end();
    check("full_done", 32'(done), 32'd1);
    check("full_mem15", tb_mem[15], 32'h1F0F0F0F);
    check_image("full", 16);

`ifdef IMEM_LOADER_CSUM_EN
    // Checksum of 01 02 04 08 is 0F; 0E must abort.
    clear_mem();
    img[0] = 32'h08040201;
    do_load(1, 16'h0001, 1'b0, -1, MODE_OK);
    wait_end();
    check("csum_ok_done", {30'd0, done, err}, 32'h2);
    clear_mem();
    do_load(1, 16'h0001, 1'b0, -1, MODE_BAD_CSUM);
    wait_end();
    check("csum_bad_flags", {29'd0, err, done, core_reset}, 32'h5);
    check("csum_bad_mem0", tb_mem[0], 32'h08040201);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the core's instruction memory: the core only reads imem, and this block fills it.
- Accepts a byte stream over a valid/ready interface; the stream is a 2-byte little-endian word count followed by the program words, each word little-endian.
- Writes each assembled 32-bit word to imem through a single-port write interface.
- Holds the core in reset until the whole image has been written.

Parameters:
- ADDR_W, 10, imem word-address width; depth = 2**ADDR_W words.
- RST_RELEASE_DLY, 2, cycles core_reset stays high after the last write completes (range 0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte.
- mem_we  out  1  imem write strobe, one cycle per word.
- mem_addr  out  ADDR_W  imem word address.
- mem_wdata  out  32  imem write data.
- core_reset  out  1  reset to the core, active-high.
- busy  out  1  a load is in progress.
- done  out  1  image loaded; sticky until the next start or reset.
- err  out  1  load aborted; sticky until the next start or reset.

Behaviour:
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, busy=0, done=0, err=0, state=IDLE.
- A reset mid-load returns every output to its reset value at the next edge.
- Byte accepted only on a cycle with rx_valid&&rx_ready. rx_ready=1 exactly in states LEN_LO, LEN_HI, DATA (and CSUM when the option is compiled in).
- All outputs are registered.
- State transitions:
  - IDLE -> LEN_LO on start.
  - LEN_LO -> LEN_HI on accept: count[7:0]=byte.
  - LEN_HI on accept: count[15:8]=byte, then:
    - count==0 -> RELEASE (or CSUM).
    - count > 2**ADDR_W -> ERR.
    - otherwise -> DATA.
  - DATA: bytes are packed LSB first.
    - On the 4th byte of a word, the next cycle shows mem_we=1 with mem_addr=word index and mem_wdata=the word.
    - The word index starts at 0 and increments after each write.
    - After word count-1 is written -> RELEASE (or CSUM).
  - RELEASE: core_reset stays 1 for RST_RELEASE_DLY cycles after the last mem_we, then -> DONE.
  - DONE: core_reset=0, done=1, busy=0.
  - ERR: err=1, core_reset=1, busy=0, rx_ready=0.
- busy=1 in LEN_LO, LEN_HI, DATA, CSUM and RELEASE.
- A start pulse in DONE or ERR clears done/err, asserts core_reset the next cycle, resets the word index and byte lane, and goes to LEN_LO.
- A start pulse while busy is ignored.
- Stalls: rx_valid low for any number of cycles pauses the FSM. The partial word and byte lane are held; no timeout.
- count == 2**ADDR_W is legal: the last write goes to address 2**ADDR_W-1. mem_addr does not wrap beyond that address.
- mem_we never asserts in any state other than the cycle following a completed word.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- With the macro:
  - After the data bytes, the FSM enters CSUM and accepts one more byte.
  - That byte must equal the XOR of all data bytes, or 8'h00 when count==0.
  - Match -> RELEASE. Mismatch -> ERR.
  - Words already written stay in imem.
- Without the macro: no CSUM state; the last word goes directly to RELEASE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum: IDLE, LEN_LO, LEN_HI, DATA, CSUM, RELEASE, DONE, ERR;
  - the localparam for the header length, 2 bytes;
  - the localparam for bytes per word, 4.
- Sub-module byte_packer:
  - inputs: byte, strobe, clear;
  - outputs: 32-bit word, word_valid pulse;
  - holds a 2-bit lane counter and the shift register.

Test Plan:
- Load of 3 words: bytes 03 00, then EF BE AD DE, 78 56 34 12, 00 00 00 00 -> mem_we at addr 0/1/2 with data DEADBEEF/12345678/00000000. core_reset falls RST_RELEASE_DLY+1 cycles after the last write; done=1.
- Header 00 00 -> no mem_we; done=1; core_reset=0.
- ADDR_W=4, header 11 00 (count 17) -> err=1, rx_ready=0, core_reset=1. A subsequent start followed by a valid 1-word load -> done=1, err=0.
- Random rx_valid gaps during a 2-word load, plus a start pulse issued mid-DATA -> same memory contents as with no gaps; the start pulse has no effect.
- reset asserted after 5 data bytes -> all outputs return to reset values; a new start and full load -> correct image.
- With IMEM_LOADER_CSUM_EN, 1 word 01 02 04 08: checksum byte 0F -> done=1; checksum byte 0E -> err=1 and core_reset=1.
